// File: rtl/sdram_test_ctrl_pkg.sv
// Shared definitions for the SDRAM exerciser: FSM state encoding,
// key and LED bit positions, error counter width.
package sdram_test_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WREQ = 3'd1,
        ST_RREQ = 3'd2,
        ST_RDAT = 3'd3,
        ST_TXB  = 3'd4,
        ST_TXG  = 3'd5,
        ST_RPT  = 3'd6
    } state_t;

    // key_vld bit positions
    localparam int unsigned KEY_WR  = 0;
    localparam int unsigned KEY_RD  = 1;
    localparam int unsigned KEY_VFY = 2;
    localparam int unsigned KEY_CLR = 3;

    // led bit positions
    localparam int unsigned LED_BUSY = 0;
    localparam int unsigned LED_PASS = 1;
    localparam int unsigned LED_FAIL = 2;
    localparam int unsigned LED_TO   = 3;

    localparam int unsigned ERR_W = 8;

    // States in which the watchdog accumulates
    function automatic logic is_wait_state(input state_t s);
        return (s == ST_WREQ) || (s == ST_RREQ) || (s == ST_RDAT) || (s == ST_TXB);
    endfunction

endpackage

// File: rtl/sdram_test_ctrl_if.sv
// Bus bundle between the exerciser, the sdram_intf request port and UART TX.
//   master: exerciser side (drives requests, address/data, UART byte)
//   slave : sdram_intf + UART side (drives acks, read data, rdy)
interface sdram_test_ctrl_if #(
    parameter int unsigned DW = 16,
    parameter int unsigned AW = 13,
    parameter int unsigned BW = 2
);
    logic          wr_req;
    logic          rd_req;
    logic          wr_ack;
    logic          rd_ack;
    logic [BW-1:0] bank;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] sd_data;
    logic          sd_data_vld;
    logic [7:0]    dout;
    logic          dout_vld;
    logic          rdy;

    modport master (
        output wr_req, rd_req, bank, addr, wdata, dout, dout_vld,
        input  wr_ack, rd_ack, sd_data, sd_data_vld, rdy
    );

    modport slave (
        input  wr_req, rd_req, bank, addr, wdata, dout, dout_vld,
        output wr_ack, rd_ack, sd_data, sd_data_vld, rdy
    );
endinterface

// File: rtl/sdram_test_watchdog.sv
// Wait-state watchdog: counts enabled cycles, cleared by the owner on any
// state change or accepted request; flags when TO_CYC cycles have elapsed.
//   clk, rst_n : clock, synchronous active-low reset
//   clr        : restart the count
//   en         : count this cycle
//   timeout_c  : combinational, high in the TO_CYC-th enabled cycle
module sdram_test_watchdog
    import sdram_test_ctrl_pkg::*;
#(
    parameter int unsigned TO_CYC = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic timeout_c
);
    localparam int unsigned CW = $clog2(TO_CYC + 1);

    logic [CW-1:0] cnt;

    assign timeout_c = en && (cnt == CW'(TO_CYC - 1));

    // Cycle counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && !timeout_c) begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/sdram_test_ctrl.sv
// SDRAM exerciser: on key pulses writes a WORDS-long pattern, reads it back
// and dumps it MSB-first over UART, or verifies it and reports an error count.
//   clk, rst_n : clock, synchronous active-low reset
//   key_vld    : [0] write, [1] read+dump, [2] verify, [3] clear status
//   led        : [0] busy, [1] pass, [2] fail, [3] timeout
//   bus        : sdram_intf request/data port and UART TX byte port
module sdram_test_ctrl
    import sdram_test_ctrl_pkg::*;
#(
    parameter int unsigned    DW        = 16,
    parameter int unsigned    AW        = 13,
    parameter int unsigned    BW        = 2,
    parameter int unsigned    WORDS     = 8,
    parameter logic [AW-1:0]  BASE_ADDR = '0,
    parameter logic [BW-1:0]  BANK      = '0,
    parameter logic [DW-1:0]  PAT_BASE  = DW'('hA500),
    parameter int unsigned    TO_CYC    = 1000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        key_vld,
    output logic [3:0]        led,
    sdram_test_ctrl_if.master bus
);
    localparam int unsigned NB  = DW / 8;
    localparam int unsigned BIW = (NB > 1) ? $clog2(NB) : 1;
    localparam int unsigned IW  = $clog2(WORDS + 1);

    state_t             state, state_nxt, take_state;
    logic [IW-1:0]      idx, idx_nxt;
    logic [ERR_W-1:0]   errs, errs_nxt;
    logic               verify, verify_nxt;
    logic [BIW-1:0]     byte_idx, byte_idx_nxt;
    logic [DW-1:0]      cap, cap_nxt;
    logic [3:0]         led_q, led_nxt;
    logic               wr_req_q, wr_req_nxt;
    logic               rd_req_q, rd_req_nxt;
    logic [AW-1:0]      addr_q, addr_nxt;
    logic [DW-1:0]      wdata_q, wdata_nxt;
    logic [BW-1:0]      bank_q, bank_nxt;
    logic [7:0]         dout_q, dout_nxt;
    logic               dout_vld_q, dout_vld_nxt;

    logic               last, wr_hit, rd_hit, take, timeout_c;
    logic               wd_en, wd_clr, start;

    assign last   = (idx == IW'(WORDS - 1));
    // An ack only counts while our own request is up
    assign wr_hit = bus.wr_ack && wr_req_q;
    assign rd_hit = bus.rd_ack && rd_req_q;
    // Read word arrives in RDAT, or together with the accepting ack
    assign take   = !timeout_c && bus.sd_data_vld &&
                    ((state == ST_RDAT) || ((state == ST_RREQ) && rd_hit));
    assign take_state = !verify ? ST_TXB : (last ? ST_RPT : ST_RREQ);
    assign start  = key_vld[KEY_WR] || key_vld[KEY_RD] || key_vld[KEY_VFY];

    assign wd_en  = is_wait_state(state);
    assign wd_clr = (state_nxt != state) || wr_hit || rd_hit;

    sdram_test_watchdog #(.TO_CYC(TO_CYC)) u_wd (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (wd_clr),
        .en        (wd_en),
        .timeout_c (timeout_c)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        if (timeout_c) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (key_vld[KEY_CLR])     state_nxt = ST_IDLE;
                    else if (key_vld[KEY_WR]) state_nxt = ST_WREQ;
                    else if (start)           state_nxt = ST_RREQ;
                end
                ST_WREQ: if (wr_hit && last) state_nxt = ST_IDLE;
                ST_RREQ: if (rd_hit) state_nxt = bus.sd_data_vld ? take_state : ST_RDAT;
                ST_RDAT: if (bus.sd_data_vld) state_nxt = take_state;
                ST_TXB:  if (bus.rdy) state_nxt = ST_TXG;
                ST_TXG: begin
                    if (byte_idx != '0) state_nxt = ST_TXB;
                    else if (!last)     state_nxt = ST_RREQ;
                    else                state_nxt = ST_IDLE;
                end
                ST_RPT:  if (bus.rdy) state_nxt = ST_IDLE;
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // Output / datapath next values (registered below)
    always_comb begin
        idx_nxt      = idx;
        errs_nxt     = errs;
        verify_nxt   = verify;
        byte_idx_nxt = byte_idx;
        cap_nxt      = cap;
        led_nxt      = led_q;
        dout_nxt     = dout_q;
        dout_vld_nxt = 1'b0;
        addr_nxt     = addr_q;
        wdata_nxt    = wdata_q;
        bank_nxt     = bank_q;

        if (timeout_c) begin
            led_nxt[LED_TO] = 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (key_vld[KEY_CLR]) begin
                        led_nxt[3:1] = 3'b000;
                    end else if (start) begin
                        led_nxt[3:1] = 3'b000;
                        idx_nxt      = '0;
                        errs_nxt     = '0;
                        verify_nxt   = !key_vld[KEY_WR] && !key_vld[KEY_RD];
                    end
                end
                ST_WREQ: begin
                    if (wr_hit) begin
                        idx_nxt = idx + IW'(1);
                        if (last) led_nxt[LED_PASS] = 1'b1;
                    end
                end
                ST_RREQ, ST_RDAT: begin
                    if (take) begin
                        if (verify) begin
                            if ((bus.sd_data != PAT_BASE + DW'(idx)) && (errs != '1))
                                errs_nxt = errs + ERR_W'(1);
                            if (!last) idx_nxt = idx + IW'(1);
                        end else begin
                            cap_nxt      = bus.sd_data;
                            byte_idx_nxt = BIW'(NB - 1);
                        end
                    end
                end
                ST_TXB: begin
                    if (bus.rdy) begin
                        dout_nxt     = 8'(cap >> {byte_idx, 3'b000});
                        dout_vld_nxt = 1'b1;
                    end
                end
                ST_TXG: begin
                    if (byte_idx != '0)  byte_idx_nxt = byte_idx - BIW'(1);
                    else if (!last)      idx_nxt = idx + IW'(1);
                    else                 led_nxt[LED_PASS] = 1'b1;
                end
                ST_RPT: begin
                    if (bus.rdy) begin
                        dout_nxt     = errs;
                        dout_vld_nxt = 1'b1;
                        if (errs == '0) led_nxt[LED_PASS] = 1'b1;
                        else            led_nxt[LED_FAIL] = 1'b1;
                    end
                end
                default: ;
            endcase
        end

        led_nxt[LED_BUSY] = (state_nxt != ST_IDLE);

        // Request drops for one cycle after every accepted ack
        wr_req_nxt = (state_nxt == ST_WREQ) && !wr_hit;
        rd_req_nxt = (state_nxt == ST_RREQ) && !rd_hit;

        if ((state_nxt == ST_WREQ) || (state_nxt == ST_RREQ)) begin
            addr_nxt = BASE_ADDR + AW'(idx_nxt);
            bank_nxt = BANK;
        end
        if (state_nxt == ST_WREQ) begin
            wdata_nxt = PAT_BASE + DW'(idx_nxt);
        end
    end

    // Output and datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx        <= '0;
            errs       <= '0;
            verify     <= 1'b0;
            byte_idx   <= '0;
            cap        <= '0;
            led_q      <= '0;
            wr_req_q   <= 1'b0;
            rd_req_q   <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            bank_q     <= '0;
            dout_q     <= '0;
            dout_vld_q <= 1'b0;
        end else begin
            idx        <= idx_nxt;
            errs       <= errs_nxt;
            verify     <= verify_nxt;
            byte_idx   <= byte_idx_nxt;
            cap        <= cap_nxt;
            led_q      <= led_nxt;
            wr_req_q   <= wr_req_nxt;
            rd_req_q   <= rd_req_nxt;
            addr_q     <= addr_nxt;
            wdata_q    <= wdata_nxt;
            bank_q     <= bank_nxt;
            dout_q     <= dout_nxt;
            dout_vld_q <= dout_vld_nxt;
        end
    end

    assign led          = led_q;
    assign bus.wr_req   = wr_req_q;
    assign bus.rd_req   = rd_req_q;
    assign bus.addr     = addr_q;
    assign bus.wdata    = wdata_q;
    assign bus.bank     = bank_q;
    assign bus.dout     = dout_q;
    assign bus.dout_vld = dout_vld_q;

endmodule
